// File: rtl/naval_game_ctrl_pkg.sv
// Shared types, geometry and 7-segment codes for the battleship game controller.
package naval_game_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_AIM,
        ST_FIRE,
        ST_RESULT,
        ST_WIN,
        ST_LOSE
    } state_t;

    localparam int unsigned MATRIX_COLS  = 5;
    localparam int unsigned MATRIX_ROWS  = 7;
    localparam int unsigned MATRIX_BITS  = 35;
    localparam int unsigned DISPLAY_BITS = 28;
    localparam int unsigned POS_W        = 3;
    localparam int unsigned IDX_W        = 6;
    localparam int unsigned CNT_W        = 6;

    // 7-segment codes, {g,f,e,d,c,b,a}, active-high
    localparam logic [6:0] SEG_0 = 7'b0111111;
    localparam logic [6:0] SEG_1 = 7'b0000110;
    localparam logic [6:0] SEG_2 = 7'b1011011;
    localparam logic [6:0] SEG_3 = 7'b1001111;
    localparam logic [6:0] SEG_4 = 7'b1100110;
    localparam logic [6:0] SEG_5 = 7'b1101101;
    localparam logic [6:0] SEG_6 = 7'b1111101;
    localparam logic [6:0] SEG_7 = 7'b0000111;
    localparam logic [6:0] SEG_8 = 7'b1111111;
    localparam logic [6:0] SEG_9 = 7'b1101111;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    // Column-major cell index shared by ship_map, shot_map and matrix_image
    function automatic logic [IDX_W-1:0] cell_index(input logic [POS_W-1:0] col,
                                                    input logic [POS_W-1:0] row);
        return IDX_W'(col) * IDX_W'(MATRIX_ROWS) + IDX_W'(row);
    endfunction

endpackage

// File: rtl/naval_game_ctrl_seg7_encoder.sv
// BCD digit to 7-segment pattern {g..a}; codes above 9 blank the digit.
module seg7_encoder
    import naval_game_ctrl_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg_c
);

    always_comb begin
        seg_c = SEG_BLANK;
        case (bcd)
            4'd0: seg_c = SEG_0;
            4'd1: seg_c = SEG_1;
            4'd2: seg_c = SEG_2;
            4'd3: seg_c = SEG_3;
            4'd4: seg_c = SEG_4;
            4'd5: seg_c = SEG_5;
            4'd6: seg_c = SEG_6;
            4'd7: seg_c = SEG_7;
            4'd8: seg_c = SEG_8;
            4'd9: seg_c = SEG_9;
            default: seg_c = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/naval_game_ctrl.sv
// Battleship game sequencer: cursor, shot/hit bookkeeping, turn FSM and display images.
// Define REVEAL_SHIPS_EN to blink the unhit ship cells after a lost game.
module naval_game_ctrl
    import naval_game_ctrl_pkg::*;
#(
    parameter int unsigned MAX_SHOTS     = 15,
    parameter int unsigned RESULT_CYCLES = 4,
    parameter int unsigned BLINK_W       = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [MATRIX_BITS-1:0]  ship_map,
    input  logic                    btn_up,
    input  logic                    btn_down,
    input  logic                    btn_left,
    input  logic                    btn_right,
    input  logic                    btn_fire,
    output logic [MATRIX_BITS-1:0]  matrix_image,
    output logic [DISPLAY_BITS-1:0] display_image,
    output logic                    game_over,
    output logic                    win
);

    localparam int unsigned HOLD_W = (RESULT_CYCLES > 1) ? $clog2(RESULT_CYCLES) : 1;

    state_t                   state;
    logic [POS_W-1:0]         col;
    logic [POS_W-1:0]         row;
    logic [CNT_W-1:0]         shots_left;
    logic [CNT_W-1:0]         hits;
    logic [MATRIX_BITS-1:0]   shot_map;
    logic [BLINK_W-1:0]       blink;
    logic [HOLD_W-1:0]        hold;

    logic [CNT_W-1:0]         ship_count;
    logic [IDX_W-1:0]         cur_idx;
    logic                     blink_phase;
    logic [MATRIX_BITS-1:0]   hit_map;
    logic [MATRIX_BITS-1:0]   matrix_next;
    logic [3:0]               bcd [4];
    logic [6:0]               seg [4];

    assign cur_idx     = cell_index(col, row);
    assign blink_phase = blink[BLINK_W-1];
    assign hit_map     = shot_map & ship_map;

    always_comb begin
        ship_count = '0;
        for (int i = 0; i < MATRIX_BITS; i++) begin
            ship_count = ship_count + CNT_W'(ship_map[i]);
        end
    end

    // Turn FSM with cursor, counters and shot bookkeeping
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_AIM;
            col        <= '0;
            row        <= '0;
            shots_left <= CNT_W'(MAX_SHOTS);
            hits       <= '0;
            shot_map   <= '0;
            blink      <= '0;
            hold       <= '0;
        end else begin
            blink <= blink + BLINK_W'(1);
            case (state)
                ST_AIM: begin
                    if (ship_count == '0) begin
                        state <= ST_WIN;
                    end else if (btn_fire) begin
                        if (!shot_map[cur_idx]) state <= ST_FIRE;
                    end else if (btn_up) begin
                        row <= (row == '0) ? POS_W'(MATRIX_ROWS - 1) : row - POS_W'(1);
                    end else if (btn_down) begin
                        row <= (row == POS_W'(MATRIX_ROWS - 1)) ? '0 : row + POS_W'(1);
                    end else if (btn_left) begin
                        col <= (col == '0) ? POS_W'(MATRIX_COLS - 1) : col - POS_W'(1);
                    end else if (btn_right) begin
                        col <= (col == POS_W'(MATRIX_COLS - 1)) ? '0 : col + POS_W'(1);
                    end
                end
                ST_FIRE: begin
                    shot_map[cur_idx] <= 1'b1;
                    if (ship_map[cur_idx]) hits <= hits + CNT_W'(1);
                    shots_left <= shots_left - CNT_W'(1);
                    hold       <= HOLD_W'(RESULT_CYCLES - 1);
                    state      <= ST_RESULT;
                end
                ST_RESULT: begin
                    // Win is checked first so the final sinking shot never reads as a loss
                    if (hold == '0) begin
                        if (hits == ship_count)      state <= ST_WIN;
                        else if (shots_left == '0)   state <= ST_LOSE;
                        else                         state <= ST_AIM;
                    end else begin
                        hold <= hold - HOLD_W'(1);
                    end
                end
                ST_WIN, ST_LOSE: state <= state;
                default: state <= ST_AIM;
            endcase
        end
    end

    always_comb begin
        matrix_next = hit_map;
        case (state)
            ST_AIM:    matrix_next[cur_idx] = blink_phase;
            ST_RESULT: matrix_next[cur_idx] = ship_map[cur_idx];
            ST_WIN:    matrix_next = '1;
            ST_LOSE: begin
`ifdef REVEAL_SHIPS_EN
                matrix_next = hit_map | (ship_map & ~shot_map & {MATRIX_BITS{blink_phase}});
`else
                matrix_next = hit_map;
`endif
            end
            default: matrix_next = hit_map;
        endcase
    end

    always_comb begin
        bcd[0] = 4'(hits % CNT_W'(10));
        bcd[1] = 4'(hits / CNT_W'(10));
        bcd[2] = 4'(shots_left % CNT_W'(10));
        bcd[3] = 4'(shots_left / CNT_W'(10));
    end

    for (genvar g = 0; g < 4; g++) begin : g_digit
        seg7_encoder u_seg7 (
            .bcd   (bcd[g]),
            .seg_c (seg[g])
        );
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            matrix_image  <= '0;
            display_image <= '0;
            game_over     <= 1'b0;
            win           <= 1'b0;
        end else begin
            matrix_image  <= matrix_next;
            display_image <= {seg[3], seg[2], seg[1], seg[0]};
            game_over     <= (state == ST_WIN) || (state == ST_LOSE);
            win           <= (state == ST_WIN);
        end
    end

endmodule

// File: tb/tb_naval_game_ctrl.sv
// Self-checking bench for naval_game_ctrl against a rule-level game model.
module tb_naval_game_ctrl;

    localparam int NCOL       = 5;
    localparam int NROW       = 7;
    localparam int NCELL      = 35;
    localparam int RES_CYC    = 4;
    localparam int MAXS       = 15;
    localparam int HALF_BLINK = 128;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [34:0] ship_map = '0;
    logic [34:0] ship_map2 = '0;
    logic        btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0, btn_fire = 1'b0;
    logic [34:0] matrix_image, matrix2;
    logic [27:0] display_image, display2;
    logic        game_over, win, over2, win2;

    naval_game_ctrl dut (
        .clk(clk), .reset(reset), .ship_map(ship_map),
        .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left),
        .btn_right(btn_right), .btn_fire(btn_fire),
        .matrix_image(matrix_image), .display_image(display_image),
        .game_over(game_over), .win(win)
    );

    naval_game_ctrl #(.MAX_SHOTS(1)) dut2 (
        .clk(clk), .reset(reset), .ship_map(ship_map2),
        .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left),
        .btn_right(btn_right), .btn_fire(btn_fire),
        .matrix_image(matrix2), .display_image(display2),
        .game_over(over2), .win(win2)
    );

    always #5 clk = ~clk;

    typedef enum {M_AIM, M_FIRE, M_RESULT, M_WIN, M_LOSE} mode_t;

    mode_t       m_mode;
    int          m_col, m_row, m_shots, m_hits, m_left_in_result, m_tick;
    logic [34:0] m_shot, m_ships;
    logic [64:0] exp_all;
    int          checks = 0;
    int          passed = 0;

    function automatic logic [6:0] seg(input int d);
        case (d)
            0: return 7'b0111111;  1: return 7'b0000110;
            2: return 7'b1011011;  3: return 7'b1001111;
            4: return 7'b1100110;  5: return 7'b1101101;
            6: return 7'b1111101;  7: return 7'b0000111;
            8: return 7'b1111111;  9: return 7'b1101111;
            default: return 7'b0000000;
        endcase
    endfunction

    task automatic model_reset(input logic [34:0] ships);
        m_ships = ships;
        m_mode  = M_AIM;
        m_col   = 0;
        m_row   = 0;
        m_shots = MAXS;
        m_hits  = 0;
        m_shot  = '0;
        m_tick  = 0;
        m_left_in_result = 0;
    endtask

    // Image the model shows for its current state; the DUT registers it one cycle later
    task automatic model_expect();
        logic [34:0] img;
        int          cur;
        logic        phase;
        phase = ((m_tick / HALF_BLINK) % 2) == 1;
        cur   = m_col * NROW + m_row;
        img   = m_shot & m_ships;
        case (m_mode)
            M_AIM:    img[6'(cur)] = phase;
            M_RESULT: img[6'(cur)] = m_ships[6'(cur)];
            M_WIN:    img = '1;
            M_LOSE: begin
`ifdef REVEAL_SHIPS_EN
                for (int i = 0; i < NCELL; i++)
                    if (m_ships[6'(i)] && !m_shot[6'(i)]) img[6'(i)] = phase;
`endif
            end
            default: ;
        endcase
        exp_all = {img, seg(m_shots / 10), seg(m_shots % 10), seg(m_hits / 10), seg(m_hits % 10),
                   (m_mode == M_WIN) || (m_mode == M_LOSE), m_mode == M_WIN};
    endtask

    task automatic model_step(input bit f, input bit u, input bit d, input bit l, input bit r);
        int cur;
        cur = m_col * NROW + m_row;
        m_tick++;
        case (m_mode)
            M_AIM: begin
                if ($countones(m_ships) == 0) m_mode = M_WIN;
                else if (f) begin
                    if (!m_shot[6'(cur)]) m_mode = M_FIRE;
                end
                else if (u) m_row = (m_row + NROW - 1) % NROW;
                else if (d) m_row = (m_row + 1) % NROW;
                else if (l) m_col = (m_col + NCOL - 1) % NCOL;
                else if (r) m_col = (m_col + 1) % NCOL;
            end
            M_FIRE: begin
                m_shot[6'(cur)] = 1'b1;
                if (m_ships[6'(cur)]) m_hits++;
                m_shots--;
                m_left_in_result = RES_CYC;
                m_mode = M_RESULT;
            end
            M_RESULT: begin
                m_left_in_result--;
                if (m_left_in_result == 0) begin
                    if (m_hits == $countones(m_ships)) m_mode = M_WIN;
                    else if (m_shots == 0)             m_mode = M_LOSE;
                    else                               m_mode = M_AIM;
                end
            end
            default: ;
        endcase
    endtask

    // One clock with the given button pulses; called and returns at a falling edge
    task automatic tick(input bit f, input bit u, input bit d, input bit l, input bit r);
        btn_fire = f; btn_up = u; btn_down = d; btn_left = l; btn_right = r;
        @(posedge clk);
        model_expect();
        model_step(f, u, d, l, r);
        @(negedge clk);
        btn_fire = 0; btn_up = 0; btn_down = 0; btn_left = 0; btn_right = 0;
    endtask

    task automatic do_reset(input logic [34:0] ships, input logic [34:0] ships2);
        @(negedge clk);
        reset = 1'b1;
        ship_map = ships;
        ship_map2 = ships2;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        model_reset(ships);
    endtask

    task automatic test_reset();
        logic [64:0] got;
        @(negedge clk);
        reset = 1'b1;
        ship_map = 35'h1;
        #1;
        got = {matrix_image, display_image, game_over, win};
        checks++;
        if (got !== '0) $display("FAIL reset_hold: got %h expected 0", got); else passed++;
        @(negedge clk);
        reset = 1'b0;
        model_reset(35'h1);
        for (int i = 0; i < 2; i++) begin
            tick(0, 0, 0, 0, 0);
            got = {matrix_image, display_image, game_over, win};
            checks++;
            if (got !== exp_all) $display("FAIL reset_idle: got %h expected %h", got, exp_all); else passed++;
        end
        checks++;
        if (display_image !== {7'b0000110, 7'b1101101, 7'b0111111, 7'b0111111})
            $display("FAIL reset_display: got %h expected 1500 pattern", display_image);
        else passed++;
    endtask

    task automatic test_moves();
        logic [64:0] got;
        bit          saw_on, saw_off;
        do_reset(35'h1, 35'h1);
        tick(0, 0, 0, 1, 0);
        tick(0, 1, 0, 0, 0);
        saw_on = 0; saw_off = 0;
        for (int i = 0; i < 300; i++) begin
            tick(0, 0, 0, 0, 0);
            got = {matrix_image, display_image, game_over, win};
            checks++;
            if (got !== exp_all) $display("FAIL moves_blink: got %h expected %h", got, exp_all); else passed++;
            if (matrix_image[34]) saw_on = 1; else saw_off = 1;
        end
        checks++;
        if ({saw_on, saw_off} !== 2'b11) $display("FAIL bit34_toggle: got %b expected 11", {saw_on, saw_off});
        else passed++;
    endtask

    task automatic test_hit_result();
        logic [64:0] got;
        do_reset(35'h1 | (35'h1 << 20), 35'h1);
        tick(1, 0, 0, 0, 0);
        for (int i = 0; i < 7; i++) begin
            tick(0, 0, 0, 0, 0);
            got = {matrix_image, display_image, game_over, win};
            checks++;
            if (got !== exp_all) $display("FAIL hit_result: got %h expected %h", got, exp_all); else passed++;
            if (i >= 1 && i <= 4) begin
                checks++;
                if (matrix_image[0] !== 1'b1) $display("FAIL hit_steady: got %b expected 1", matrix_image[0]);
                else passed++;
            end
        end
        checks++;
        if (display_image !== {seg(1), seg(4), seg(0), seg(1)})
            $display("FAIL hit_display: got %h expected 14/01", display_image);
        else passed++;
        // refire on the same cell must be a no-op
        tick(1, 0, 0, 0, 0);
        for (int i = 0; i < 7; i++) begin
            tick(0, 0, 0, 0, 0);
            got = {matrix_image, display_image, game_over, win};
            checks++;
            if (got !== exp_all) $display("FAIL refire: got %h expected %h", got, exp_all); else passed++;
        end
        checks++;
        if ({display_image, game_over} !== {seg(1), seg(4), seg(0), seg(1), 1'b0})
            $display("FAIL refire_display: got %h expected 14/01", display_image);
        else passed++;
    endtask

    task automatic test_fire_priority();
        logic [64:0] got;
        do_reset(35'h1 << 7, 35'h1);
        tick(0, 0, 0, 0, 1);
        tick(1, 1, 0, 0, 0);
        for (int i = 0; i < 7; i++) begin
            tick(0, 0, 0, 0, 0);
            got = {matrix_image, display_image, game_over, win};
            checks++;
            if (got !== exp_all) $display("FAIL fire_prio: got %h expected %h", got, exp_all); else passed++;
        end
        checks++;
        if ({display_image, win} !== {seg(1), seg(4), seg(0), seg(1), 1'b1})
            $display("FAIL fire_prio_win: got %h/%b expected 14/01 win", display_image, win);
        else passed++;
    endtask

    task automatic test_mid_reset();
        logic [64:0] got;
        do_reset(35'h3, 35'h1);
        tick(1, 0, 0, 0, 0);
        tick(0, 0, 0, 0, 0);
        tick(0, 0, 0, 0, 0);
        reset = 1'b1;
        #1;
        got = {matrix_image, display_image, game_over, win};
        checks++;
        if (got !== '0) $display("FAIL mid_reset: got %h expected 0", got); else passed++;
        @(negedge clk);
        reset = 1'b0;
        model_reset(35'h3);
        tick(0, 0, 0, 0, 0);
        got = {matrix_image, display_image, game_over, win};
        checks++;
        if (got !== exp_all) $display("FAIL mid_reset_after: got %h expected %h", got, exp_all); else passed++;
    endtask

    task automatic test_empty_board();
        do_reset('0, 35'h1);
        tick(0, 0, 0, 0, 0);
        tick(0, 0, 0, 0, 0);
        checks++;
        if ({matrix_image, game_over, win} !== {35'h7_FFFF_FFFF, 1'b1, 1'b1})
            $display("FAIL empty_board: got %h %b%b expected all ones 11", matrix_image, game_over, win);
        else passed++;
    endtask

    task automatic test_one_shot();
        bit saw_on, saw_off;
        do_reset(35'h1, 35'h1 << 8);
        tick(1, 0, 0, 0, 0);
        repeat (5) tick(0, 0, 0, 0, 0);
        checks++;
        if (over2 !== 1'b0) $display("FAIL lose_early: got %b expected 0", over2); else passed++;
        tick(0, 0, 0, 0, 0);
        checks++;
        if ({over2, win2} !== 2'b10) $display("FAIL lose_flags: got %b expected 10", {over2, win2}); else passed++;
        saw_on = 0; saw_off = 0;
        for (int i = 0; i < 300; i++) begin
            tick(0, 0, 0, 0, 0);
            if (matrix2[8]) saw_on = 1; else saw_off = 1;
            checks++;
            if ((matrix2 & ~(35'h1 << 8)) !== '0) $display("FAIL lose_image: got %h expected 0 outside bit 8", matrix2);
            else passed++;
        end
        checks++;
`ifdef REVEAL_SHIPS_EN
        if ({saw_on, saw_off} !== 2'b11) $display("FAIL reveal: got %b expected 11", {saw_on, saw_off}); else passed++;
`else
        if (saw_on !== 1'b0) $display("FAIL no_reveal: got %b expected 0", saw_on); else passed++;
`endif
        do_reset(35'h1, 35'h1 << 8);
        tick(0, 0, 0, 0, 1);
        tick(0, 0, 1, 0, 0);
        tick(1, 0, 0, 0, 0);
        repeat (6) tick(0, 0, 0, 0, 0);
        checks++;
        if ({matrix2, display2, over2, win2} !== {35'h7_FFFF_FFFF, seg(0), seg(0), seg(0), seg(1), 1'b1, 1'b1})
            $display("FAIL one_shot_win: got %h %h %b%b expected all ones 00/01 11", matrix2, display2, over2, win2);
        else passed++;
    endtask

    task automatic test_random();
        logic [64:0] got;
        logic [34:0] ships;
        for (int g = 0; g < 4; g++) begin
            ships = '0;
            for (int i = 0; i < NCELL; i++)
                if ($urandom_range(0, 5) == 0) ships[6'(i)] = 1'b1;
            if (ships == '0) ships[6'($urandom_range(0, 34))] = 1'b1;
            do_reset(ships, 35'h1);
            for (int c = 0; c < 400; c++) begin
                tick($urandom_range(0, 4) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                     $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
                got = {matrix_image, display_image, game_over, win};
                checks++;
                if (got !== exp_all) $display("FAIL random g%0d c%0d: got %h expected %h", g, c, got, exp_all);
                else passed++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_moves();
        test_hit_result();
        test_fire_priority();
        test_mid_reset();
        test_empty_board();
        test_one_shot();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
